// File: rtl/multicycle_control.sv
// Multi-cycle instruction sequencer: walks each instruction through
// fetch, decode, execute, memory and write-back, and drives the shared
// datapath control fields from the opcode latched during decode.
// Memory waits in IF and MEM are guarded by a not-ready timeout that
// parks the controller in ERR until reset.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IF    | fetch via memory, PC += 4 and IR load when memory is ready
//   ID    | latch opcode, reject unknown opcodes
//   EX    | ALU computes R-type result, immediate result or address
//   MEM   | data memory read (lw) or write (sw), waits on mem_ready
//   WB    | register file write, instruction retires
//   ERR   | memory timeout seen, absorbing until reset
module multicycle_control #(
  parameter int OPCODE_W    = 6,
  parameter int OP_RTYPE    = 4,
  parameter int OP_ADDIU    = 12,
  parameter int OP_SUBIU    = 13,
  parameter int OP_SW       = 16,
  parameter int OP_LW       = 17,
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] OpCode,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                IRWrite,
  output logic                IorD,
  output logic                RegWrite,
  output logic                RegDst,
  output logic                ALUSrcA,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                MemtoReg,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ALUOp,
  output logic [2:0]          state,
  output logic                instr_done,
  output logic                illegal_op,
  output logic                err
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_ERR = 3'd5
  } state_t;

  localparam logic [OPCODE_W-1:0] OPC_R   = OPCODE_W'(OP_RTYPE);
  localparam logic [OPCODE_W-1:0] OPC_ADD = OPCODE_W'(OP_ADDIU);
  localparam logic [OPCODE_W-1:0] OPC_SUB = OPCODE_W'(OP_SUBIU);
  localparam logic [OPCODE_W-1:0] OPC_SW  = OPCODE_W'(OP_SW);
  localparam logic [OPCODE_W-1:0] OPC_LW  = OPCODE_W'(OP_LW);

  // Timeout compare value; meaningless (and unused) when the timeout is disabled.
  localparam bit              TO_EN   = (MEM_TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_t              curState, nextState;
  logic [OPCODE_W-1:0] opQ;
  logic [TO_W-1:0]     toCnt;
  logic                timedOut;
  logic                knownOp;
  logic                waitState;

  assign knownOp = (OpCode == OPC_R)   || (OpCode == OPC_ADD) ||
                   (OpCode == OPC_SUB) || (OpCode == OPC_SW)  ||
                   (OpCode == OPC_LW);

  assign waitState = (curState == S_IF) || (curState == S_MEM);
  assign timedOut  = TO_EN && waitState && (toCnt == TO_LAST) && !mem_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) curState <= S_IF;
    else     curState <= nextState;
  end

  // Opcode latch, loaded only while decoding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   opQ <= '0;
    else if (curState == S_ID) opQ <= OpCode;
  end

  // Counts consecutive not-ready cycles spent in one wait state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      toCnt <= '0;
    else if (!waitState || mem_ready || (nextState != curState))
      toCnt <= '0;
    else
      toCnt <= toCnt + 1'b1;
  end

  // Next-state and control decode; everything is held at 0 while rst is high.
  always_comb begin
    nextState  = curState;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    IorD       = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    ALUSrcA    = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    err        = 1'b0;

    case (curState)
      S_IF: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b01;
        PCWrite = mem_ready;
        IRWrite = mem_ready;
        if (timedOut)       nextState = S_ERR;
        else if (mem_ready) nextState = S_ID;
      end
      S_ID: begin
        if (knownOp) begin
          nextState = S_EX;
        end else begin
          illegal_op = 1'b1;
          nextState  = S_IF;
        end
      end
      S_EX: begin
        ALUSrcA = 1'b1;
        case (opQ)
          OPC_R: begin
            ALUSrcB   = 2'b00;
            ALUOp     = 2'b10;
            nextState = S_WB;
          end
          OPC_ADD: begin
            ALUSrcB   = 2'b10;
            ALUOp     = 2'b01;
            nextState = S_WB;
          end
          OPC_SUB: begin
            ALUSrcB   = 2'b10;
            ALUOp     = 2'b00;
            nextState = S_WB;
          end
          OPC_LW, OPC_SW: begin
            ALUSrcB   = 2'b10;
            ALUOp     = 2'b01;
            nextState = S_MEM;
          end
          default: nextState = S_IF;
        endcase
      end
      S_MEM: begin
        IorD     = 1'b1;
        MemRead  = (opQ == OPC_LW);
        MemWrite = (opQ == OPC_SW);
        if (timedOut) begin
          nextState = S_ERR;
        end else if (mem_ready) begin
          if (opQ == OPC_SW) begin
            instr_done = 1'b1;
            nextState  = S_IF;
          end else begin
            nextState  = S_WB;
          end
        end
      end
      S_WB: begin
        RegWrite   = 1'b1;
        RegDst     = (opQ == OPC_R);
        MemtoReg   = (opQ == OPC_LW);
        instr_done = 1'b1;
        nextState  = S_IF;
      end
      S_ERR: begin
        err = 1'b1;
      end
      default: nextState = S_IF;
    endcase

    // Reset acts on the outputs immediately so an in-flight write is cut off.
    if (rst) begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      IorD       = 1'b0;
      RegWrite   = 1'b0;
      RegDst     = 1'b0;
      ALUSrcA    = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      MemtoReg   = 1'b0;
      ALUSrcB    = 2'b00;
      ALUOp      = 2'b00;
      instr_done = 1'b0;
      illegal_op = 1'b0;
      err        = 1'b0;
    end
  end

  assign state = rst ? 3'd0 : curState;

endmodule
